// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler
//   Timestep scheduler for a chain of leaky-integrate-and-fire neurons. One
//   shared membrane-update datapath visits N_NEURONS virtual neurons in
//   round-robin order (FETCH -> CALC -> WRITE per neuron), one full pass per
//   timestep. Neuron i>0 also receives `weight` when neuron i-1 spiked in the
//   previous timestep.
//
//   Optional feature: define LIF_AUTO_STEP_EN to add a free-running step timer
//   (period STEP_PERIOD). Its requests are ORed with start; a request that
//   lands while busy is dropped and sets the sticky overrun flag.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   current    external input current, captured when a step is accepted
//   start      one-cycle step request (ignored unless idle)
//   cfg_we     config write strobe (honoured only when idle)
//   cfg_addr   0: thr, 1: leak_sh[2:0], 2: refr[3:0], 3: weight
//   cfg_data   config write data
//   mon_sel    neuron whose membrane is mirrored on state_out
//   spike_out  spike vector of the last completed timestep
//   state_out  membrane of the monitored neuron (updated at its WRITE)
//   busy       high from FETCH through DONE
//   done       one-cycle pulse at timestep completion
//   overrun    sticky dropped-auto-step flag (constant 0 without the macro)
module lif_step_scheduler #(
  parameter int N_NEURONS   = 8,
  parameter int IDX_W       = 3,
  parameter int STEP_PERIOD = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           current,
  input  logic                 start,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [7:0]           cfg_data,
  input  logic [IDX_W-1:0]     mon_sel,
  output logic [N_NEURONS-1:0] spike_out,
  output logic [7:0]           state_out,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]     idx;
  logic [7:0]           mem   [N_NEURONS];
  logic [3:0]           refc  [N_NEURONS];
  logic [N_NEURONS-1:0] spk_acc;

  logic [7:0] thr;
  logic [2:0] leak_sh;
  logic [3:0] refr;
  logic [7:0] weight;

  logic [7:0] cur_q;
  logic [7:0] v_q;
  logic [3:0] r_q;
  logic [7:0] nxt_q;
  logic [3:0] rnx_q;
  logic       spk_q;

  logic       step_req;
  logic       accept;

  // Clamp the widened sum back into the 8-bit membrane range.
  function automatic logic [7:0] sat8(input logic [9:0] x);
    return (x > 10'd255) ? 8'd255 : x[7:0];
  endfunction

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign accept = (state == S_IDLE) && step_req;

`ifdef LIF_AUTO_STEP_EN
  localparam int CNT_W = $clog2(STEP_PERIOD + 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             auto_req;

  assign auto_req = (tick_cnt == CNT_W'(STEP_PERIOD - 1));
  assign step_req = start | auto_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      tick_cnt <= auto_req ? '0 : tick_cnt + 1'b1;
      // A timer tick is never queued: while busy it is lost and flagged.
      if (auto_req && busy) overrun <= 1'b1;
    end
  end
`else
  logic unused_period;

  assign unused_period = (STEP_PERIOD != 0);
  assign step_req      = start;
  assign overrun       = 1'b0;
`endif

  // Membrane update for the neuron currently held in v_q / r_q.
  logic       prev_spk;
  logic [9:0] inc;
  logic [7:0] leak_amt;
  logic [7:0] sum;
  logic [7:0] calc_v;
  logic [3:0] calc_r;
  logic       calc_s;

  // spike_out still holds the previous timestep here; it only changes in DONE.
  assign prev_spk = (idx != '0) && spike_out[idx - 1'b1];

  always_comb begin
    inc      = {2'b00, cur_q} + (prev_spk ? {2'b00, weight} : 10'd0);
    leak_amt = (leak_sh == 3'd0) ? 8'd0 : (v_q >> leak_sh);
    // leak_amt never exceeds v_q, so the subtraction cannot underflow.
    sum      = sat8({2'b00, v_q - leak_amt} + inc);
    calc_v   = sum;
    calc_r   = 4'd0;
    calc_s   = 1'b0;
    if (r_q != 4'd0) begin
      calc_v = 8'd0;
      calc_r = r_q - 4'd1;
    end else if (sum >= thr) begin
      calc_v = 8'd0;
      calc_r = refr;
      calc_s = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (step_req) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_CALC;
      S_CALC:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      spike_out <= '0;
      state_out <= 8'd0;
      cur_q     <= 8'd0;
      thr       <= 8'd200;
      leak_sh   <= 3'd1;
      refr      <= 4'd2;
      weight    <= 8'd40;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i]  <= 8'd0;
        refc[i] <= 4'd0;
      end
    end else begin
      if ((state == S_IDLE) && cfg_we) begin
        case (cfg_addr)
          2'd0:    thr     <= cfg_data;
          2'd1:    leak_sh <= cfg_data[2:0];
          2'd2:    refr    <= cfg_data[3:0];
          default: weight  <= cfg_data;
        endcase
      end
      if (accept) begin
        cur_q <= current;
        idx   <= '0;
      end
      // ---- FETCH -> CALC boundary: neuron state read out ----
      if (state == S_FETCH) begin
        v_q <= mem[idx];
        r_q <= refc[idx];
      end
      // ---- CALC -> WRITE boundary: update result captured ----
      if (state == S_CALC) begin
        nxt_q <= calc_v;
        rnx_q <= calc_r;
        spk_q <= calc_s;
      end
      // ---- WRITE: commit neuron state, advance index ----
      if (state == S_WRITE) begin
        mem[idx]     <= nxt_q;
        refc[idx]    <= rnx_q;
        spk_acc[idx] <= spk_q;
        if (idx == mon_sel) state_out <= nxt_q;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
      if (state == S_DONE) spike_out <= spk_acc;
    end
  end

endmodule

// File: tb/tb_lif_step_scheduler.sv
module tb_lif_step_scheduler;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   current;
  logic         start;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [7:0]   cfg_data;
  logic [2:0]   mon_sel;
  logic [N-1:0] spike_out;
  logic [7:0]   state_out;
  logic         busy;
  logic         done;
  logic         overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int       m_mem [N];
  int       m_ref [N];
  bit [N-1:0] m_spk;
  int       m_thr, m_sh, m_refr, m_w;
  int       m_state_out;

  lif_step_scheduler #(.N_NEURONS(N), .IDX_W(3), .STEP_PERIOD(1000)) dut (
    .clk(clk), .rst_n(rst_n), .current(current), .start(start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .mon_sel(mon_sel), .spike_out(spike_out), .state_out(state_out),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0;
      m_ref[i] = 0;
    end
    m_spk = '0;
    m_thr = 200; m_sh = 1; m_refr = 2; m_w = 40;
    m_state_out = 0;
  endfunction

  // One timestep over all neurons. mon_at[i] is the neuron index selected
  // for monitoring at the moment neuron i is written back.
  function automatic void model_step(input int cur, input int mon_at [N]);
    bit [N-1:0] nspk;
    int inc, lk, sum;
    nspk = '0;
    for (int i = 0; i < N; i++) begin
      inc = cur + ((i > 0 && m_spk[i-1]) ? m_w : 0);
      if (m_ref[i] > 0) begin
        m_mem[i] = 0;
        m_ref[i] = m_ref[i] - 1;
      end else begin
        lk  = (m_sh == 0) ? 0 : (m_mem[i] >> m_sh);
        sum = m_mem[i] - lk + inc;
        if (sum > 255) sum = 255;
        if (sum >= m_thr) begin
          m_mem[i] = 0;
          m_ref[i] = m_refr;
          nspk[i]  = 1'b1;
        end else begin
          m_mem[i] = sum;
        end
      end
      if (mon_at[i] == i) m_state_out = m_mem[i];
    end
    m_spk = nspk;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    case (a)
      2'd0: m_thr  = d;
      2'd1: m_sh   = d & 7;
      2'd2: m_refr = d & 15;
      default: m_w = d;
    endcase
  endtask

  // Runs one timestep in a fixed 40-cycle window. noise: extra start pulses
  // at cycles 5 and 10 plus a config write to thr at cycle 7 (both must be
  // ignored). chg_at>0: mon_sel switches to chg_sel at that cycle.
  task automatic run_step(input logic [7:0] cur, input bit noise,
                          input int chg_at, input logic [2:0] chg_sel);
    int lat, dones;
    int mon_at [N];
    int sel0;
    sel0 = mon_sel;
    for (int i = 0; i < N; i++)
      mon_at[i] = (chg_at > 0 && 3*i + 3 >= chg_at) ? int'(chg_sel) : sel0;
    start = 1'b1; current = cur;
    tick();
    start = 1'b0;
    current = 8'($urandom);
    lat = 1; dones = 0;
    check("busy_after_start", busy, 1);
    while (lat < 40) begin
      if (done) begin
        dones++;
        if (dones == 1) check("done_latency", lat, 3*N + 1);
      end
      start  = (noise && (lat == 5 || lat == 10));
      cfg_we = (noise && lat == 7);
      cfg_addr = 2'd0; cfg_data = 8'h10;
      if (chg_at > 0 && lat == chg_at) mon_sel = chg_sel;
      tick();
      lat++;
    end
    start = 1'b0; cfg_we = 1'b0;
    model_step(cur, mon_at);
    check("done_count", dones, 1);
    check("busy_idle", busy, 0);
    check("spike_out", spike_out, m_spk);
    check("state_out", state_out, m_state_out);
    check("overrun", overrun, 0);
  endtask

  initial begin
    rst_n = 1'b0; current = '0; start = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; mon_sel = '0;
    do_reset();

    // Reset state
    check("rst_spike_out", spike_out, 0);
    check("rst_state_out", state_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);

    // Constant drive 120 with defaults: 120, 180, then spike, refractory
    mon_sel = 3'd0;
    run_step(8'd120, 1'b0, 0, 3'd0);
    check("n0_step1", state_out, 120);
    run_step(8'd120, 1'b0, 0, 3'd0);
    check("n0_step2", state_out, 180);
    run_step(8'd120, 1'b0, 0, 3'd0);
    check("n0_spike_step3", spike_out[0], 1);
    run_step(8'd120, 1'b0, 0, 3'd0);
    check("n0_refr_step4", state_out, 0);
    mon_sel = 3'd1;
    run_step(8'd120, 1'b0, 0, 3'd0);
    mon_sel = 3'd0;
    run_step(8'd120, 1'b0, 0, 3'd0);
    check("n0_step6", state_out, 120);

    // Saturation at thr=255, ignored starts and busy config write
    do_reset();
    cfg_write(2'd0, 8'd255);
    run_step(8'd255, 1'b1, 0, 3'd0);
    check("sat_spike_n0", spike_out[0], 1);
    mon_sel = 3'd0;
    run_step(8'd254, 1'b0, 0, 3'd0);
    run_step(8'd254, 1'b0, 0, 3'd0);

    // thr=0 and refr=0: every neuron fires every step
    do_reset();
    cfg_write(2'd0, 8'd0);
    cfg_write(2'd2, 8'hF0);
    run_step(8'd3, 1'b0, 0, 3'd0);
    check("thr0_all_a", spike_out, 8'hFF);
    run_step(8'd0, 1'b0, 0, 3'd0);
    check("thr0_all_b", spike_out, 8'hFF);

    // mon_sel changing mid-step
    do_reset();
    cfg_write(2'd1, 8'd0);
    mon_sel = 3'd2;
    run_step(8'd50, 1'b0, 10, 3'd1);
    mon_sel = 3'd2;
    run_step(8'd50, 1'b0, 10, 3'd5);

    // Randomized steps and configuration
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write(2'($urandom_range(0, 3)), 8'($urandom));
      if (m_thr < 40) cfg_write(2'd0, 8'($urandom_range(60, 255)));
      mon_sel = 3'($urandom_range(0, N - 1));
      run_step(8'($urandom), 1'b0, 0, 3'd0);
    end

    // Reset in the middle of a step
    start = 1'b1; current = 8'd77;
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_spike_out", spike_out, 0);
    check("midrst_state_out", state_out, 0);
    rst_n = 1'b1;
    model_reset();
    mon_sel = 3'd7;
    run_step(8'd120, 1'b0, 0, 3'd0);
    check("midrst_n7_fresh", state_out, 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
